pc_redirect: RTL

Fetch-side PC controller that consumes the jump predictor's outputs: holds the fetch PC, advances it sequentially, and steers it to a predicted target, a recovered fall-through address, or a corrected target. It also generates per-stage squash signals for the front-end pipeline registers. It sits between the predictor/hazard logic and instruction memory, driving the address the IF stage fetches each cycle.

---
 rtl/pc_redirect_if.sv | 56 +++++
 rtl/pc_redirect.sv | 123 ++++++++++++
 2 files changed

// File: rtl/pc_redirect_if.sv
// pc_redirect_if: predictor/hazard control into the fetch PC controller and
// fetch address / squash outputs back to the front end.
// Optional stats ports exist only when PC_REDIRECT_STATS_EN is defined.
interface pc_redirect_if #(
    parameter int unsigned FLUSH_DEPTH = 3
);
    localparam int unsigned PC_W = 16;

    logic                   stall;
    logic                   halt;
    logic                   jump_pred;
    logic [PC_W-1:0]        jump_pred_adr;
    logic                   jump_pred_miss;
    logic                   jump_pred_adr_miss;
    logic [PC_W-1:0]        pcinc_evac;
    logic [PC_W-1:0]        ALUres_mem;
    logic [PC_W-1:0]        pc;
    logic [PC_W-1:0]        pcinc;
    logic                   fetch_valid;
    logic                   redirect;
    logic [FLUSH_DEPTH-1:0] flush_vec;
`ifdef PC_REDIRECT_STATS_EN
    logic [PC_W-1:0]        pred_count;
    logic [PC_W-1:0]        miss_count;

    // Control side: predictor, hazard unit and front-end pipeline.
    modport master (
        output stall, halt, jump_pred, jump_pred_adr, jump_pred_miss,
               jump_pred_adr_miss, pcinc_evac, ALUres_mem,
        input  pc, pcinc, fetch_valid, redirect, flush_vec,
               pred_count, miss_count
    );

    // PC controller side.
    modport slave (
        input  stall, halt, jump_pred, jump_pred_adr, jump_pred_miss,
               jump_pred_adr_miss, pcinc_evac, ALUres_mem,
        output pc, pcinc, fetch_valid, redirect, flush_vec,
               pred_count, miss_count
    );
`else
    // Control side: predictor, hazard unit and front-end pipeline.
    modport master (
        output stall, halt, jump_pred, jump_pred_adr, jump_pred_miss,
               jump_pred_adr_miss, pcinc_evac, ALUres_mem,
        input  pc, pcinc, fetch_valid, redirect, flush_vec
    );

    // PC controller side.
    modport slave (
        input  stall, halt, jump_pred, jump_pred_adr, jump_pred_miss,
               jump_pred_adr_miss, pcinc_evac, ALUres_mem,
        output pc, pcinc, fetch_valid, redirect, flush_vec
    );
`endif
endinterface

// File: rtl/pc_redirect.sv
// pc_redirect: fetch PC controller. Holds the fetch PC, advances it, steers it
// to predicted / recovered / corrected targets and drives front-end squashes.
// Optional: PC_REDIRECT_STATS_EN adds saturating pred_count / miss_count.
module pc_redirect #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int unsigned FLUSH_DEPTH = 3
) (
    input  logic           clk,
    input  logic           reset,
    pc_redirect_if.slave   bus
);
    localparam int unsigned PC_W = 16;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [PC_W-1:0]        pc_q;
    logic [PC_W-1:0]        pc_d;
    logic [PC_W-1:0]        pcinc_c;
    logic                   fetch_valid_q;
    logic                   redirect_q;
    logic                   redirect_d;
    logic [FLUSH_DEPTH-1:0] flush_c;
    logic                   pred_evt_c;
    logic                   miss_evt_c;

    assign pcinc_c = pc_q + PC_W'(1);

    // Next-PC select: corrected target > fall-through recovery > halt > prediction > stall.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        redirect_d = 1'b0;
        flush_c    = '0;
        pred_evt_c = 1'b0;
        miss_evt_c = 1'b0;
        case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                miss_evt_c = bus.jump_pred_miss | bus.jump_pred_adr_miss;
                if (bus.jump_pred_adr_miss) begin
                    pc_d       = bus.ALUres_mem;
                    redirect_d = 1'b1;
                    flush_c    = '1;
                end else if (bus.jump_pred_miss) begin
                    pc_d       = bus.pcinc_evac;
                    redirect_d = 1'b1;
                    flush_c    = '1;
                end else if (bus.halt) begin
                    state_d = S_HALT;
                end else if (bus.jump_pred) begin
                    pc_d       = bus.jump_pred_adr;
                    redirect_d = 1'b1;
                    flush_c    = FLUSH_DEPTH'(1);
                    pred_evt_c = 1'b1;
                end else if (!bus.stall) begin
                    pc_d = pcinc_c;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    // State, PC and registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_BOOT;
            pc_q          <= RESET_PC;
            fetch_valid_q <= 1'b0;
            redirect_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_valid_q <= (state_d == S_RUN);
            redirect_q    <= redirect_d;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pcinc       = pcinc_c;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.redirect    = redirect_q;
    assign bus.flush_vec   = flush_c;

`ifdef PC_REDIRECT_STATS_EN
    logic [PC_W-1:0] pred_count_q;
    logic [PC_W-1:0] miss_count_q;

    // Saturating event counters for accepted predictions and resolved misses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pred_count_q <= '0;
            miss_count_q <= '0;
        end else begin
            if (pred_evt_c && (pred_count_q != '1)) begin
                pred_count_q <= pred_count_q + PC_W'(1);
            end
            if (miss_evt_c && (miss_count_q != '1)) begin
                miss_count_q <= miss_count_q + PC_W'(1);
            end
        end
    end

    assign bus.pred_count = pred_count_q;
    assign bus.miss_count = miss_count_q;
`else
    // Event strobes only feed the optional counters.
    logic unused_evt_c;
    assign unused_evt_c = pred_evt_c ^ miss_evt_c;
`endif
endmodule
